dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_lane_align.sv | 66 ++++++
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: funct3 codes, FSM states, latency range.
// No timing of its own; no backpressure.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LATENCY_MIN = 0;
    localparam int LATENCY_MAX = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I loads/stores: enables, replicated write data, extended read data.
// Purely combinational; no backpressure.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_al,
    output logic [31:0] rdata_ext,
    output logic        misalign,
    output logic        illegal
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        shifted = raw_word >> {addr_lo, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
    end

    always_comb begin
        byte_en   = 4'b0000;
        wdata_al  = 32'h0;
        rdata_ext = 32'h0;
        misalign  = 1'b0;
        illegal   = 1'b0;
        case (funct3)
            F3_B: begin
                byte_en   = 4'b0001 << addr_lo;
                wdata_al  = {4{wdata[7:0]}};
                rdata_ext = {{24{byte_v[7]}}, byte_v};
            end
            F3_H: begin
                misalign  = addr_lo[0];
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_al  = {2{wdata[15:0]}};
                rdata_ext = {{16{half_v[15]}}, half_v};
            end
            F3_W: begin
                misalign  = (addr_lo != 2'b00);
                byte_en   = 4'b1111;
                wdata_al  = wdata;
                rdata_ext = raw_word;
            end
            // Unsigned variants exist only for loads.
            F3_BU: begin
                illegal   = is_store;
                rdata_ext = {24'h0, byte_v};
            end
            F3_HU: begin
                illegal   = is_store;
                misalign  = addr_lo[0];
                rdata_ext = {16'h0, half_v};
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: serialized load/store with LATENCY wait states; response after accept+LATENCY+1 edges.
// One transaction in flight; req_ready low until the response handshakes, response held while rsp_ready=0.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [2:0] LAT_LD = 3'(LATENCY);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic          oor, access, acc_err, mem_we;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_al, rdata_ext;
    logic          misalign, illegal;

    assign idx     = addr_q[AW+1:2];
    assign oor     = ((addr_q >> (AW + 2)) != 32'h0);
    assign access  = (state_q == ST_WAIT) && (cnt_q == 3'd0);
    assign acc_err = misalign | illegal | oor;
    // State is forced to IDLE while rst is low, so an aborted store never writes.
    assign mem_we  = access && we_q && !acc_err;

    dmem_lane_align u_align (
        .is_store  (we_q),
        .funct3    (f3_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .raw_word  (mem[idx]),
        .byte_en   (byte_en),
        .wdata_al  (wdata_al),
        .rdata_ext (rdata_ext),
        .misalign  (misalign),
        .illegal   (illegal)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = LAT_LD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    rdata_d = (we_q || acc_err) ? 32'h0 : rdata_ext;
                    err_d   = acc_err;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= wdata_al[8*b +: 8];
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: lane/extension table, error cases, RESP hold, async abort.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;
    int edge_cnt = 0;

    logic [31:0] r_dat;
    logic        r_err;
    int          r_lat;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_rsp(input string tag);
        int budget = 0;
        while (!rsp_valid && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check({tag, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
    endtask

    // One complete transaction; returns data, error flag and accept-to-valid edge count.
    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
        int acc;
        int budget = 0;
        @(negedge clk);
        while (!req_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        acc = edge_cnt;
        req_valid = 1'b0;
        wait_rsp(tag);
        lat   = edge_cnt - acc;
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic ld(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] exp);
        txn(tag, 1'b0, f3, addr, 32'h0, r_dat, r_err, r_lat);
        check(tag, r_dat, exp);
        check({tag, "_err"}, 32'(r_err), 32'd0);
    endtask

    task automatic st(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] data);
        txn(tag, 1'b1, f3, addr, data, r_dat, r_err, r_lat);
        check({tag, "_err"}, 32'(r_err), 32'd0);
        check({tag, "_rdata"}, r_dat, 32'h0);
    endtask

    task automatic bad(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data);
        txn(tag, we, f3, addr, data, r_dat, r_err, r_lat);
        check({tag, "_err"}, 32'(r_err), 32'd1);
        check({tag, "_rdata"}, r_dat, 32'h0);
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Store then word/half/byte reads with latency check
        txn("sw10", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, r_dat, r_err, r_lat);
        check("sw10_lat", 32'(r_lat), 32'(LAT + 1));
        check("sw10_err", 32'(r_err), 32'd0);
        check("sw10_rdata", r_dat, 32'h0);
        txn("lw10", 1'b0, F3_W, 32'h10, 32'h0, r_dat, r_err, r_lat);
        check("lw10", r_dat, 32'hDEADBEEF);
        check("lw10_lat", 32'(r_lat), 32'(LAT + 1));
        ld("lb13",  F3_B,  32'h13, 32'hFFFFFFDE);
        ld("lbu13", F3_BU, 32'h13, 32'h000000DE);
        ld("lh12",  F3_H,  32'h12, 32'hFFFFDEAD);
        ld("lhu10", F3_HU, 32'h10, 32'h0000BEEF);

        st("sb11", F3_B, 32'h11, 32'h00000055);
        ld("lw10_sb", F3_W, 32'h10, 32'hDEAD55EF);

        // Errors leave storage untouched
        st("sw00", F3_W, 32'h0, 32'h11223344);
        bad("lw12_mis", 1'b0, F3_W, 32'h12, 32'h0);
        bad("sh11_mis", 1'b1, F3_H, 32'h11, 32'h0000FFFF);
        bad("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'h0);
        bad("st_f3_100", 1'b1, F3_BU, 32'h10, 32'h0);
        bad("lw400_oor", 1'b0, F3_W, 32'h400, 32'h0);
        bad("sw400_oor", 1'b1, F3_W, 32'h400, 32'hFFFFFFFF);
        ld("lw10_after_err", F3_W, 32'h10, 32'hDEAD55EF);
        ld("lw00_after_oor", F3_W, 32'h0, 32'h11223344);

        st("sh12", F3_H, 32'h12, 32'h00001234);
        ld("lh12_pos", F3_H, 32'h12, 32'h00001234);
        ld("lb11", F3_B, 32'h11, 32'h00000055);

        // Response held under rsp_ready=0; request presented during RESP is not taken early
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp("hold");
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h10;
        req_wdata = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, 32'h123455EF);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_rdata", rsp_rdata, 32'h0);
        check("idle_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("next_acc_busy", 32'(busy), 32'd1);
        wait_rsp("next_sw");
        check("next_sw_err", 32'(rsp_err), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        ld("lw10_cafe", F3_W, 32'h10, 32'hCAFEF00D);

        // Asynchronous abort of a store still in WAIT
        st("sw20", F3_W, 32'h20, 32'hAAAA5555);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h20;
        req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_busy_clr", 32'(busy), 32'd0);
        check("abort_valid", 32'(rsp_valid), 32'd0);
        check("abort_rdata", rsp_rdata, 32'h0);
        check("abort_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        ld("lw20_old", F3_W, 32'h20, 32'hAAAA5555);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
